mod4_dir_decoder: RTL and testbench

- Inverse of the board's 2-bit reversible mod-4 counter (x=0 counts up, x=1 counts down).
- Samples the 2-bit counter state y2y1 on each debounced button release and recovers the direction bit x from consecutive samples.
- Also keeps a signed step position and flags illegal jumps.
- Sits on the EGO1 board: switches or the counter outputs feed `y_in`, a push-button strobes samples, results drive LEDs.

---
 rtl/mod4_dir_decoder.sv | 175 +++++++++++++++++
 tb/tb_mod4_dir_decoder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod4_dir_decoder.sv
// mod4_dir_decoder: recovers the direction bit of a 2-bit reversible mod-4
// counter from successive samples of its state. A sample is taken on every
// debounced release of a push-button. The decoder also keeps a signed step
// position and a sticky flag for illegal (two-step) jumps.
// Optional feature macro: STEP_HIST_EN adds a 4-bit history of decoded
// direction bits on output hist (newest in hist[0]).
module mod4_dir_decoder #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int POS_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              y_in,
  input  logic                    btn_sample,
  output logic                    x_out,
  output logic                    valid,
  output logic                    stall,
  output logic                    err,
  output logic signed [POS_W-1:0] pos,
  output logic [1:0]              cur_state,
  output logic                    sample_pulse
`ifdef STEP_HIST_EN
  ,
  output logic [3:0]              hist
`endif
);

  localparam int               CNT_W    = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  typedef enum logic {
    EMPTY,
    TRACK
  } state_t;

  state_t state_q, state_d;

  logic [1:0]       y_meta, y_sync;
  logic             btn_meta, btn_sync;
  logic             btn_deb;
  logic [CNT_W-1:0] deb_cnt;
  logic             fall;

  logic                    x_d, valid_d, stall_d, err_d, pulse_d;
  logic signed [POS_W-1:0] pos_d;
  logic [1:0]              cur_d;
  logic [1:0]              step;
`ifdef STEP_HIST_EN
  logic [3:0]              hist_d;
`endif

  // Two-flop synchronizers for the asynchronous counter state and button
  always_ff @(posedge clk) begin
    if (rst) begin
      y_meta   <= 2'b00;
      y_sync   <= 2'b00;
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      y_meta   <= y_in;
      y_sync   <= y_meta;
      btn_meta <= btn_sample;
      btn_sync <= btn_meta;
    end
  end

  // Debounce: accept a new level only after it has differed long enough;
  // the release (1->0) of the accepted level becomes the one-cycle fall event
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_deb <= 1'b0;
      deb_cnt <= '0;
      fall    <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (btn_sync == btn_deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        btn_deb <= btn_sync;
        deb_cnt <= '0;
        fall    <= btn_deb;
      end else begin
        deb_cnt <= deb_cnt + CNT_ONE;
      end
    end
  end

  // Next-state and output decode for each accepted sample
  always_comb begin
    state_d = state_q;
    x_d     = x_out;
    valid_d = valid;
    stall_d = stall;
    err_d   = err;
    pos_d   = pos;
    cur_d   = cur_state;
    pulse_d = 1'b0;
    step    = y_sync - cur_state;
`ifdef STEP_HIST_EN
    hist_d  = hist;
`endif
    if (fall) begin
      pulse_d = 1'b1;
      cur_d   = y_sync;
      stall_d = 1'b0;
      case (state_q)
        EMPTY: begin
          state_d = TRACK;
        end
        TRACK: begin
          case (step)
            2'd1: begin
              x_d     = 1'b0;
              pos_d   = pos + POS_ONE;
              valid_d = 1'b1;
`ifdef STEP_HIST_EN
              hist_d  = {hist[2:0], 1'b0};
`endif
            end
            2'd3: begin
              x_d     = 1'b1;
              pos_d   = pos - POS_ONE;
              valid_d = 1'b1;
`ifdef STEP_HIST_EN
              hist_d  = {hist[2:0], 1'b1};
`endif
            end
            2'd0: begin
              stall_d = 1'b1;
            end
            default: begin
              err_d   = 1'b1;
              valid_d = 1'b0;
            end
          endcase
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      x_out        <= 1'b0;
      valid        <= 1'b0;
      stall        <= 1'b0;
      err          <= 1'b0;
      pos          <= '0;
      cur_state    <= 2'b00;
      sample_pulse <= 1'b0;
`ifdef STEP_HIST_EN
      hist         <= 4'b0000;
`endif
    end else begin
      state_q      <= state_d;
      x_out        <= x_d;
      valid        <= valid_d;
      stall        <= stall_d;
      err          <= err_d;
      pos          <= pos_d;
      cur_state    <= cur_d;
      sample_pulse <= pulse_d;
`ifdef STEP_HIST_EN
      hist         <= hist_d;
`endif
    end
  end

endmodule

// File: tb/tb_mod4_dir_decoder.sv
// tb_mod4_dir_decoder: self-checking bench for mod4_dir_decoder with
// DEB_CYCLES=4, POS_W=8; directed scenarios plus a randomized run checked
// against a behavioural model of the direction decoder.
module tb_mod4_dir_decoder;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [1:0]        y_in = 2'b00;
  logic              btn_sample = 1'b0;
  logic              x_out, valid, stall, err, sample_pulse;
  logic signed [7:0] pos;
  logic [1:0]        cur_state;
`ifdef STEP_HIST_EN
  logic [3:0]        hist;
`endif

  int passed = 0;
  int total  = 0;
  int pulse_cnt = 0;

  bit         m_track;
  int         m_cur, m_pos;
  bit         m_x, m_valid, m_stall, m_err;
  logic [3:0] m_hist;

  mod4_dir_decoder #(.DEB_CYCLES(4), .POS_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .y_in(y_in),
    .btn_sample(btn_sample),
    .x_out(x_out),
    .valid(valid),
    .stall(stall),
    .err(err),
    .pos(pos),
    .cur_state(cur_state),
    .sample_pulse(sample_pulse)
`ifdef STEP_HIST_EN
    ,
    .hist(hist)
`endif
  );

  always #5 clk = ~clk;

  // Count every observed sample pulse
  always @(negedge clk) if (sample_pulse) pulse_cnt++;

  task automatic model_reset();
    m_track = 0; m_cur = 0; m_pos = 0;
    m_x = 0; m_valid = 0; m_stall = 0; m_err = 0; m_hist = 4'b0000;
  endtask

  task automatic model_sample(input int s);
    int d;
    m_stall = 0;
    if (m_track) begin
      d = (s - m_cur + 4) % 4;
      if (d == 1) begin
        m_x = 0; m_pos = (m_pos + 1) % 256; m_valid = 1; m_hist = {m_hist[2:0], 1'b0};
      end else if (d == 3) begin
        m_x = 1; m_pos = (m_pos + 255) % 256; m_valid = 1; m_hist = {m_hist[2:0], 1'b1};
      end else if (d == 0) begin
        m_stall = 1;
      end else begin
        m_err = 1; m_valid = 0;
      end
    end
    m_track = 1;
    m_cur = s;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; btn_sample = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Press and release the button with y_in held at y; report pulse latency
  // (negedges after release, -1 on timeout) and whether the pulse was 1 cycle
  task automatic do_sample(input logic [1:0] y, output int lat, output bit one_shot);
    @(negedge clk);
    y_in = y;
    btn_sample = 1'b1;
    repeat (8) @(negedge clk);
    btn_sample = 1'b0;
    lat = -1;
    one_shot = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (sample_pulse) begin
        lat = i;
        break;
      end
    end
    if (lat > 0) begin
      @(negedge clk);
      one_shot = !sample_pulse;
    end
    model_sample(int'(y));
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({x_out, valid, stall, err, pos, cur_state, sample_pulse} !== 15'd0)
      $display("[TB] FAIL reset_outputs: got %0h expected 0",
               {x_out, valid, stall, err, pos, cur_state, sample_pulse});
    else passed++;
  endtask

  task automatic test_up_count();
    logic [1:0] ys [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    int lat, start;
    bit os;
    apply_reset();
    start = pulse_cnt;
    for (int i = 0; i < 5; i++) begin
      do_sample(ys[i], lat, os);
      total++;
      if (lat < 6 || lat > 8 || !os)
        $display("[TB] FAIL up_pulse_timing: got latency %0d one_shot %0d expected 6..8 and 1", lat, os);
      else passed++;
      if (i > 0) begin
        total++;
        if (x_out !== 1'b0) $display("[TB] FAIL up_x: got %0b expected 0", x_out);
        else passed++;
      end
    end
    total++;
    if (pos !== 8'd4) $display("[TB] FAIL up_pos: got %0h expected 04", pos); else passed++;
    total++;
    if (valid !== 1'b1 || err !== 1'b0)
      $display("[TB] FAIL up_valid_err: got %0b%0b expected 10", valid, err);
    else passed++;
    total++;
    if (pulse_cnt - start !== 5) $display("[TB] FAIL up_pulse_count: got %0d expected 5", pulse_cnt - start);
    else passed++;
  endtask

  task automatic test_down_count();
    int lat;
    bit os;
    apply_reset();
    do_sample(2'd0, lat, os);
    do_sample(2'd3, lat, os);
    total++;
    if (x_out !== 1'b1 || pos !== 8'hFF)
      $display("[TB] FAIL down_first: got x %0b pos %0h expected x 1 pos ff", x_out, pos);
    else passed++;
    do_sample(2'd2, lat, os);
    total++;
    if (pos !== 8'hFE) $display("[TB] FAIL down_pos: got %0h expected fe", pos); else passed++;
`ifdef STEP_HIST_EN
    total++;
    if (hist !== 4'b0011) $display("[TB] FAIL down_hist: got %b expected 0011", hist); else passed++;
`endif
  endtask

  task automatic test_stall();
    int lat;
    bit os;
    apply_reset();
    do_sample(2'd1, lat, os);
    do_sample(2'd1, lat, os);
    total++;
    if (stall !== 1'b1 || pos !== 8'd0 || valid !== 1'b0)
      $display("[TB] FAIL stall: got stall %0b pos %0h valid %0b expected 1 00 0", stall, pos, valid);
    else passed++;
  endtask

  task automatic test_error();
    int lat;
    bit os;
    apply_reset();
    do_sample(2'd0, lat, os);
    do_sample(2'd2, lat, os);
    total++;
    if (err !== 1'b1 || valid !== 1'b0 || pos !== 8'd0)
      $display("[TB] FAIL err_jump: got err %0b valid %0b pos %0h expected 1 0 00", err, valid, pos);
    else passed++;
    do_sample(2'd3, lat, os);
    total++;
    if (valid !== 1'b1 || x_out !== 1'b0 || pos !== 8'd1 || err !== 1'b1)
      $display("[TB] FAIL err_recover: got valid %0b x %0b pos %0h err %0b expected 1 0 01 1",
               valid, x_out, pos, err);
    else passed++;
  endtask

  task automatic test_bounce();
    int start;
    apply_reset();
    start = pulse_cnt;
    @(negedge clk);
    y_in = 2'd1;
    btn_sample = 1'b1;
    repeat (8) @(negedge clk);
    btn_sample = 1'b0; repeat (2) @(negedge clk);
    btn_sample = 1'b1; repeat (2) @(negedge clk);
    btn_sample = 1'b0; repeat (2) @(negedge clk);
    btn_sample = 1'b1; repeat (2) @(negedge clk);
    btn_sample = 1'b0; repeat (12) @(negedge clk);
    repeat (10) @(negedge clk);
    model_sample(1);
    total++;
    if (pulse_cnt - start !== 1) $display("[TB] FAIL bounce_pulses: got %0d expected 1", pulse_cnt - start);
    else passed++;
    total++;
    if (cur_state !== 2'd1) $display("[TB] FAIL bounce_state: got %0d expected 1", cur_state);
    else passed++;
  endtask

  task automatic test_reset_mid_debounce();
    int lat, start;
    bit os;
    apply_reset();
    do_sample(2'd0, lat, os);
    do_sample(2'd1, lat, os);
    @(negedge clk);
    y_in = 2'd2;
    btn_sample = 1'b1;
    repeat (8) @(negedge clk);
    btn_sample = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    start = pulse_cnt;
    repeat (20) @(negedge clk);
    total++;
    if (pulse_cnt - start !== 0) $display("[TB] FAIL abort_pulses: got %0d expected 0", pulse_cnt - start);
    else passed++;
    total++;
    if ({x_out, valid, stall, err, pos, cur_state} !== 14'd0)
      $display("[TB] FAIL abort_outputs: got %0h expected 0", {x_out, valid, stall, err, pos, cur_state});
    else passed++;
  endtask

  task automatic test_wrap();
    int lat;
    bit os;
    apply_reset();
    do_sample(2'd0, lat, os);
    for (int i = 1; i <= 128; i++) begin
      do_sample(2'(i % 4), lat, os);
      if (i == 127) begin
        total++;
        if (pos !== 8'h7F) $display("[TB] FAIL wrap_127: got %0h expected 7f", pos); else passed++;
      end
    end
    total++;
    if (pos !== 8'h80 || x_out !== 1'b0 || err !== 1'b0)
      $display("[TB] FAIL wrap_128: got pos %0h x %0b err %0b expected 80 0 0", pos, x_out, err);
    else passed++;
  endtask

  task automatic test_random();
    int lat;
    bit os;
    logic [1:0] y;
    logic [7:0] exp_pos;
    apply_reset();
    for (int n = 0; n < 40; n++) begin
      y = 2'($urandom_range(0, 3));
      do_sample(y, lat, os);
      exp_pos = m_pos[7:0];
      total++;
      if (x_out !== m_x || valid !== m_valid || stall !== m_stall || err !== m_err ||
          pos !== exp_pos || cur_state !== 2'(m_cur) || lat < 0)
        $display("[TB] FAIL random_step%0d: got x%0b v%0b s%0b e%0b pos %0h cur %0d lat %0d expected x%0b v%0b s%0b e%0b pos %0h cur %0d",
                 n, x_out, valid, stall, err, pos, cur_state, lat,
                 m_x, m_valid, m_stall, m_err, exp_pos, m_cur);
      else passed++;
`ifdef STEP_HIST_EN
      total++;
      if (hist !== m_hist) $display("[TB] FAIL random_hist%0d: got %b expected %b", n, hist, m_hist);
      else passed++;
`endif
    end
  endtask

  initial begin
    $display("[TB] starting mod4_dir_decoder bench");
    test_reset();
    test_up_count();
    test_down_count();
    test_stall();
    test_error();
    test_bounce();
    test_reset_mid_debounce();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
